// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_rd_return.sv
// Read-return path: remembers which port issued the last read and routes the
// memory's registered read data back to that port only.
module dmem_rd_return
    import dmem_pkg::*;
#(
    parameter int DW = DMEM_DW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          issue_cpu_rd_i,
    input  logic          issue_dma_rd_i,
    input  logic [DW-1:0] m_rdata_i,
    output logic          c_rvalid_o,
    output logic [DW-1:0] c_rdata_o,
    output logic          x_rvalid_o,
    output logic [DW-1:0] x_rdata_o
);

    owner_e own_q;
    owner_e own_d;

    // Next owner tag from whichever read is issued this cycle.
    always_comb begin
        own_d = OWN_NONE;
        if (issue_cpu_rd_i) begin
            own_d = OWN_CPU;
        end else if (issue_dma_rd_i) begin
            own_d = OWN_DMA;
        end else begin
            own_d = OWN_NONE;
        end
    end

    // Owner tag register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            own_q <= OWN_NONE;
        end else begin
            own_q <= own_d;
        end
    end

    // Demux: the non-owner port always sees zero data.
    always_comb begin
        c_rvalid_o = 1'b0;
        c_rdata_o  = {DW{1'b0}};
        x_rvalid_o = 1'b0;
        x_rdata_o  = {DW{1'b0}};
        case (own_q)
            OWN_CPU: begin
                c_rvalid_o = 1'b1;
                c_rdata_o  = m_rdata_i;
            end
            OWN_DMA: begin
                x_rvalid_o = 1'b1;
                x_rdata_o  = m_rdata_i;
            end
            default: begin
                c_rvalid_o = 1'b0;
                x_rvalid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between CPU single accesses (priority)
// and auto-incrementing DMA bursts, with bounded DMA starvation.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [AW-1:0] x_len,
    input  logic [DW-1:0] x_wdata,
    output logic          x_gnt,
    output logic          x_wready,
    output logic          x_rvalid,
    output logic [DW-1:0] x_rdata,
    output logic          x_done,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [3:0]    MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [AW-1:0] ONE_C      = AW'(1);

    state_e        state_q,    state_d;
    logic [AW-1:0] baddr_q,    baddr_d;
    logic [AW-1:0] bremain_q,  bremain_d;
    logic          bwe_q,      bwe_d;
    logic          last_dma_q, last_dma_d;
    logic [3:0]    wait_q,     wait_d;
    logic          done_q,     done_d;

    logic          cpu_issue_s;
    logic          dma_issue_s;
    logic          gnt_x_s;
    logic          dma_we_s;
    logic [AW-1:0] dma_addr_s;

    // Arbitration and burst sequencing: next state, counters and issue decode.
    always_comb begin
        state_d     = state_q;
        baddr_d     = baddr_q;
        bremain_d   = bremain_q;
        bwe_d       = bwe_q;
        wait_d      = wait_q;
        done_d      = 1'b0;
        cpu_issue_s = 1'b0;
        dma_issue_s = 1'b0;
        gnt_x_s     = 1'b0;
        dma_we_s    = 1'b0;
        dma_addr_s  = {AW{1'b0}};
        case (state_q)
            IDLE: begin
                if (c_req && (wait_q < MAX_WAIT_C)) begin
                    cpu_issue_s = 1'b1;
                    if (x_req) begin
                        wait_d = wait_q + 4'd1;
                    end else begin
                        wait_d = 4'd0;
                    end
                end else if (x_req) begin
                    gnt_x_s     = 1'b1;
                    dma_issue_s = 1'b1;
                    dma_we_s    = x_we;
                    dma_addr_s  = x_addr;
                    wait_d      = 4'd0;
                    if (x_len == {AW{1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        baddr_d   = x_addr + ONE_C;
                        bremain_d = x_len;
                        bwe_d     = x_we;
                        state_d   = BURST;
                    end
                end else begin
                    wait_d = 4'd0;
                end
            end
            BURST: begin
                wait_d = 4'd0;
                // CPU may steal only a slot that follows a DMA beat, so its wait is at most 1.
                if (c_req && last_dma_q) begin
                    cpu_issue_s = 1'b1;
                end else begin
                    dma_issue_s = 1'b1;
                    dma_we_s    = bwe_q;
                    dma_addr_s  = baddr_q;
                    baddr_d     = baddr_q + ONE_C;
                    bremain_d   = bremain_q - ONE_C;
                    if (bremain_q == ONE_C) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        last_dma_d = dma_issue_s;
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baddr_q    <= {AW{1'b0}};
            bremain_q  <= {AW{1'b0}};
            bwe_q      <= 1'b0;
            last_dma_q <= 1'b0;
            wait_q     <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baddr_q    <= baddr_d;
            bremain_q  <= bremain_d;
            bwe_q      <= bwe_d;
            last_dma_q <= last_dma_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
        end
    end

    // Memory port mux; grants are forced low while reset is held.
    always_comb begin
        c_gnt    = 1'b0;
        x_gnt    = 1'b0;
        x_wready = 1'b0;
        m_we     = 1'b0;
        m_addr   = {AW{1'b0}};
        m_wdata  = {DW{1'b0}};
        if (!reset_n) begin
            c_gnt = 1'b0;
        end else if (cpu_issue_s) begin
            c_gnt   = 1'b1;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (dma_issue_s) begin
            x_gnt    = gnt_x_s;
            x_wready = 1'b1;
            m_we     = dma_we_s;
            m_addr   = dma_addr_s;
            m_wdata  = x_wdata;
        end else begin
            m_we = 1'b0;
        end
    end

    assign x_done = done_q;

    dmem_rd_return #(
        .DW(DW)
    ) u_rd_return (
        .clock          (clock),
        .reset_n        (reset_n),
        .issue_cpu_rd_i (c_gnt & ~c_we),
        .issue_dma_rd_i (x_wready & ~dma_we_s),
        .m_rdata_i      (m_rdata),
        .c_rvalid_o     (c_rvalid),
        .c_rdata_o      (c_rdata),
        .x_rvalid_o     (x_rvalid),
        .x_rdata_o      (x_rdata)
    );

endmodule
